// File: rtl/wb_lsu_pkg.sv
// wb_lsu_pkg: shared definitions for the load/store unit and its bus slaves.
//   size_e  - request size codes (byte, half, word, tag)
//   state_e - LSU control states
//   SEL_*   - wishbone byte-select encodings per access size
//   sel_for_size / is_misaligned - helpers shared by the LSU and bus models
package wb_lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_TAG  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_RESP = 2'b10,
    ST_GAP  = 2'b11
  } state_e;

  // Data is never lane-shifted, so sel only tells the slave how wide the
  // access is; the slave uses the address to place it.
  localparam logic [3:0] SEL_BYTE = 4'b0001;
  localparam logic [3:0] SEL_HALF = 4'b0011;
  localparam logic [3:0] SEL_WORD = 4'b1111;
  localparam logic [3:0] SEL_TAG  = 4'b0101;

  function automatic logic [3:0] sel_for_size(size_e size);
    logic [3:0] sel;
    case (size)
      SIZE_BYTE: sel = SEL_BYTE;
      SIZE_HALF: sel = SEL_HALF;
      SIZE_WORD: sel = SEL_WORD;
      default:   sel = SEL_TAG;
    endcase
    return sel;
  endfunction

  // Tag accesses are exempt: the tag lives in address bits, not in a lane.
  function automatic logic is_misaligned(size_e size, logic [1:0] addr_lo);
    return ((size == SIZE_HALF) && addr_lo[0]) ||
           ((size == SIZE_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/wb_lsu_if.sv
// wb_lsu_if: wishbone bus between the LSU (master) and a slave.
//   wb_addr_o  - byte address            wb_data_o - right-aligned write data
//   wb_sel_o   - access-width encoding   wb_we_o   - write enable
//   wb_cyc_o   - bus cycle               wb_stb_o  - strobe (mirrors cyc)
//   wb_ack_i   - slave acknowledge       wb_data_i - right-aligned read data
// Signal names are taken from the master's point of view.
interface wb_lsu_if;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_data_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;
  logic [31:0] wb_data_i;

  modport master (
    output wb_addr_o, wb_data_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_ack_i, wb_data_i
  );

  modport slave (
    input  wb_addr_o, wb_data_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_ack_i, wb_data_i
  );
endinterface

// File: rtl/wb_lsu.sv
// wb_lsu: single-outstanding load/store unit bridging a core request port
// onto a wishbone bus.
//   wb_clk_i, wb_rst_i         - clock, synchronous active-high reset
//   req_valid_i / req_ready_o  - request handshake (ready only in IDLE)
//   req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_data_i - request
//   resp_valid_o, resp_data_o, resp_err_o - one-cycle completion
//   wb                         - wishbone master port
// Flow: IDLE -> BUS -> RESP -> GAP -> IDLE; misaligned requests go
// IDLE -> RESP directly and never touch the bus. Every output is a register.
module wb_lsu
  import wb_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,  // 1..64, fits the 6-bit ack counter
  parameter int GAP_CYCLES     = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_data_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_data_o,
  output logic        resp_err_o,
  wb_lsu_if.master    wb
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [5:0] TIMEOUT_LAST = 6'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e            state_reg, state_next;
  logic [5:0]        ack_cnt_reg, ack_cnt_next;
  logic [GAP_W-1:0]  gap_cnt_reg, gap_cnt_next;
  size_e             size_reg, size_next;
  logic              unsigned_reg, unsigned_next;
  logic [31:0]       addr_reg, addr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [3:0]        sel_reg, sel_next;
  logic              we_reg, we_next;
  logic              cyc_reg, cyc_next;
  logic              ready_reg, ready_next;
  logic              resp_valid_reg, resp_valid_next;
  logic              resp_err_reg, resp_err_next;
  logic [31:0]       resp_data_reg, resp_data_next;

  function automatic logic [31:0] extend_load(size_e size, logic is_unsigned,
                                              logic [31:0] d);
    logic [31:0] r;
    case (size)
      SIZE_BYTE: r = is_unsigned ? {24'b0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
      SIZE_HALF: r = is_unsigned ? {16'b0, d[15:0]} : {{16{d[15]}}, d[15:0]};
      SIZE_WORD: r = d;
      default:   r = {28'b0, d[3:0]};
    endcase
    return r;
  endfunction

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg      <= ST_IDLE;
      ack_cnt_reg    <= '0;
      gap_cnt_reg    <= '0;
      size_reg       <= SIZE_BYTE;
      unsigned_reg   <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      sel_reg        <= '0;
      we_reg         <= 1'b0;
      cyc_reg        <= 1'b0;
      ready_reg      <= 1'b1;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_data_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      ack_cnt_reg    <= ack_cnt_next;
      gap_cnt_reg    <= gap_cnt_next;
      size_reg       <= size_next;
      unsigned_reg   <= unsigned_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      sel_reg        <= sel_next;
      we_reg         <= we_next;
      cyc_reg        <= cyc_next;
      ready_reg      <= ready_next;
      resp_valid_reg <= resp_valid_next;
      resp_err_reg   <= resp_err_next;
      resp_data_reg  <= resp_data_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    ack_cnt_next    = ack_cnt_reg;
    gap_cnt_next    = gap_cnt_reg;
    size_next       = size_reg;
    unsigned_next   = unsigned_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    sel_next        = sel_reg;
    we_next         = we_reg;
    cyc_next        = cyc_reg;
    resp_valid_next = 1'b0;
    resp_err_next   = 1'b0;
    resp_data_next  = resp_data_reg;

    case (state_reg)
      ST_IDLE: begin
        if (req_valid_i) begin
          size_next     = size_e'(req_size_i);
          unsigned_next = req_unsigned_i;
          if (is_misaligned(size_e'(req_size_i), req_addr_i[1:0])) begin
            state_next      = ST_RESP;
            resp_valid_next = 1'b1;
            resp_err_next   = 1'b1;
            resp_data_next  = '0;
          end else begin
            state_next   = ST_BUS;
            addr_next    = req_addr_i;
            wdata_next   = req_data_i;
            sel_next     = sel_for_size(size_e'(req_size_i));
            we_next      = req_we_i;
            cyc_next     = 1'b1;
            ack_cnt_next = '0;
          end
        end
      end
      ST_BUS: begin
        if (wb.wb_ack_i) begin
          state_next      = ST_RESP;
          cyc_next        = 1'b0;
          we_next         = 1'b0;
          resp_valid_next = 1'b1;
          resp_data_next  = we_reg ? 32'd0
                                   : extend_load(size_reg, unsigned_reg, wb.wb_data_i);
        end else if (ack_cnt_reg == TIMEOUT_LAST) begin
          // The counter holds the index of the current BUS cycle, so this
          // is the last one allowed.
          state_next      = ST_RESP;
          cyc_next        = 1'b0;
          we_next         = 1'b0;
          resp_valid_next = 1'b1;
          resp_err_next   = 1'b1;
          resp_data_next  = '0;
        end else begin
          ack_cnt_next = ack_cnt_reg + 6'd1;
        end
      end
      ST_RESP: begin
        gap_cnt_next = '0;
        state_next   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          state_next = ST_IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Registered so that ready tracks the state it will be in next cycle.
    ready_next = (state_next == ST_IDLE);
  end

  assign req_ready_o  = ready_reg;
  assign resp_valid_o = resp_valid_reg;
  assign resp_err_o   = resp_err_reg;
  assign resp_data_o  = resp_data_reg;

  assign wb.wb_addr_o = addr_reg;
  assign wb.wb_data_o = wdata_reg;
  assign wb.wb_sel_o  = sel_reg;
  assign wb.wb_we_o   = we_reg;
  assign wb.wb_cyc_o  = cyc_reg;
  assign wb.wb_stb_o  = cyc_reg;

endmodule
